// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter in front of the register file write port,
// with a per-register busy scoreboard that generates issue-stage hazard stalls.
module regfile_wb_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_rd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic                          rf_reg_write,
   output logic [ADDR_WIDTH-1:0]         rf_rd,
   output logic [DATA_WIDTH-1:0]         rf_write_data,
   input  logic                          issue_valid,
   input  logic [ADDR_WIDTH-1:0]         issue_rd,
   input  logic [ADDR_WIDTH-1:0]         issue_rs1,
   input  logic [ADDR_WIDTH-1:0]         issue_rs2,
   output logic                          issue_stall,
   output logic [31:0]                   busy_mask
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      grant_idx;
   logic [PTR_W-1:0]      next_ptr;
   logic                  transfer;
   logic [ADDR_WIDTH-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  wr_q;
   logic [31:0]           busy_q;
   logic [31:0]           busy_n;
   logic                  issue_set;

   // Scanning from the highest offset down lets the nearest valid requester
   // after ptr overwrite any farther one, so no early exit is needed.
   always_comb begin
      logic [PTR_W-1:0] idx;
      int               sum;
      req_ready = '0;
      grant_idx = '0;
      transfer  = 1'b0;
      idx       = '0;
      sum       = 0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = int'(ptr) + k;
         idx = PTR_W'((sum >= NUM_REQ) ? (sum - NUM_REQ) : sum);
         if (req_valid[idx]) begin
            grant_idx = idx;
            transfer  = 1'b1;
         end
      end
      if (reset) begin
         transfer = 1'b0;
      end
      if (transfer) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      sel_rd   = '0;
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            sel_rd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign next_ptr = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

   // Stall looks only at the registered mask: a write completing this cycle
   // does not release a dependent instruction until the next cycle.
   assign issue_stall = ~reset & issue_valid &
                        (busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]);
   assign issue_set   = issue_valid & ~issue_stall & (issue_rd != '0);

   // Clear is applied before set so a new producer issued in the same cycle
   // as the old one retires keeps the register marked busy.
   always_comb begin
      busy_n = busy_q;
      if (transfer) begin
         busy_n[sel_rd] = 1'b0;
      end
      if (issue_set) begin
         busy_n[issue_rd] = 1'b1;
      end
      busy_n[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr           <= '0;
         wr_q          <= 1'b0;
         rf_rd         <= '0;
         rf_write_data <= '0;
         busy_q        <= '0;
      end else begin
         if (transfer) begin
            ptr <= next_ptr;
         end
         wr_q <= transfer && (sel_rd != '0);
         if (transfer && (sel_rd != '0)) begin
            rf_rd         <= sel_rd;
            rf_write_data <= sel_data;
         end
         busy_q <= busy_n;
      end
   end

   // A write registered just before reset is suppressed rather than committed.
   assign rf_reg_write = wr_q & ~reset;
   assign busy_mask    = busy_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a driver runs a high-level model and
// queues expected register writes; an independent monitor retires them.
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int DW = 32;
   localparam int AW = 5;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_rd;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic              rf_reg_write;
   logic [AW-1:0]     rf_rd;
   logic [DW-1:0]     rf_write_data;
   logic              issue_valid;
   logic [AW-1:0]     issue_rd;
   logic [AW-1:0]     issue_rs1;
   logic [AW-1:0]     issue_rs2;
   logic              issue_stall;
   logic [31:0]       busy_mask;

   regfile_wb_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data), .req_ready(req_ready),
      .rf_reg_write(rf_reg_write), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
      .issue_rs2(issue_rs2), .issue_stall(issue_stall), .busy_mask(busy_mask)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] rd;
      logic [DW-1:0] data;
      int            due;
   } wr_t;

   wr_t         expQ[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          mPtr = 0;
   bit          mBusy[32];
   bit          pend[N];
   logic [AW-1:0] hRd[N];
   logic [DW-1:0] hData[N];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle: drive, predict, check combinational outputs, advance the model.
   task automatic applyStimulus(input bit rst, input logic [N-1:0] v,
                                input logic [N*AW-1:0] rdv, input logic [N*DW-1:0] dv,
                                input bit iv, input logic [AW-1:0] ird,
                                input logic [AW-1:0] irs1, input logic [AW-1:0] irs2);
      int            g;
      logic [N-1:0]  expReady;
      bit            expStall;
      logic [31:0]   busyVec;
      logic [AW-1:0] r;
      @(posedge clk);
      #1;
      reset = rst; req_valid = v; req_rd = rdv; req_data = dv;
      issue_valid = iv; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
      if (rst) expQ.delete();
      g = -1;
      if (!rst) begin
         for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(mPtr + k) % N]) g = (mPtr + k) % N;
         end
      end
      expReady = '0;
      if (g >= 0) expReady[g] = 1'b1;
      expStall = !rst && iv && (mBusy[irs1] || mBusy[irs2] || mBusy[ird]);
      busyVec = '0;
      for (int b = 0; b < 32; b++) busyVec[b] = mBusy[b];
      @(negedge clk);
      checkOutput("req_ready", 32'(req_ready), 32'(expReady));
      checkOutput("issue_stall", 32'(issue_stall), 32'(expStall));
      checkOutput("busy_mask", busy_mask, busyVec);
      if (rst) begin
         mPtr = 0;
         for (int b = 0; b < 32; b++) mBusy[b] = 1'b0;
      end else begin
         if (g >= 0) begin
            r = rdv[g*AW +: AW];
            if (r != 0) expQ.push_back('{rd: r, data: dv[g*DW +: DW], due: cyc + 1});
            mBusy[r] = 1'b0;
            mPtr = (g + 1) % N;
         end
         if (iv && !expStall && ird != 0) mBusy[ird] = 1'b1;
         mBusy[0] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
         pend[i]  = v[i] && (g != i);
         hRd[i]   = rdv[i*AW +: AW];
         hData[i] = dv[i*DW +: DW];
      end
   endtask

   task automatic drainReq();
      logic [N-1:0]    v;
      logic [N*AW-1:0] rdv;
      logic [N*DW-1:0] dv;
      for (int t = 0; t < 8; t++) begin
         v = '0; rdv = '0; dv = '0;
         for (int i = 0; i < N; i++) begin
            v[i] = pend[i];
            rdv[i*AW +: AW] = hRd[i];
            dv[i*DW +: DW]  = hData[i];
         end
         if (v == '0) break;
         applyStimulus(1'b0, v, rdv, dv, 1'b0, '0, '0, '0);
      end
   endtask

   task automatic randomStep();
      logic [N-1:0]    v;
      logic [N*AW-1:0] rdv;
      logic [N*DW-1:0] dv;
      for (int i = 0; i < N; i++) begin
         if (pend[i]) begin
            v[i] = 1'b1;
            rdv[i*AW +: AW] = hRd[i];
            dv[i*DW +: DW]  = hData[i];
         end else begin
            v[i] = ($urandom_range(0, 9) < 6);
            rdv[i*AW +: AW] = AW'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            dv[i*DW +: DW]  = $urandom;
         end
      end
      applyStimulus($urandom_range(0, 99) == 0, v, rdv, dv, $urandom_range(0, 1) == 1,
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
   endtask

   // Monitor: every strobe must match the oldest queued write in the cycle it is due.
   always @(negedge clk) begin
      wr_t e;
      if (rf_reg_write === 1'b1) begin
         if (expQ.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_write: got rd %0d data %h, expected no write (cycle %0d)",
                     rf_rd, rf_write_data, cyc);
         end else begin
            e = expQ.pop_front();
            checkOutput("rf_rd", 32'(rf_rd), 32'(e.rd));
            checkOutput("rf_write_data", rf_write_data, e.data);
            checkOutput("write_cycle", cyc, e.due);
         end
      end else if (expQ.size() > 0 && expQ[0].due <= cyc) begin
         e = expQ.pop_front();
         vectors++;
         miscompares++;
         $display("[TB] FAIL missing_write: got no strobe, expected rd %0d data %h (cycle %0d)",
                  e.rd, e.data, cyc);
      end
   end

   initial begin
      reset = 1'b1; req_valid = '0; req_rd = '0; req_data = '0;
      issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
      for (int b = 0; b < 32; b++) mBusy[b] = 1'b0;
      for (int i = 0; i < N; i++) begin pend[i] = 1'b0; hRd[i] = '0; hData[i] = '0; end

      $display("[TB] reset and single ALU write");
      applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0, '0);
      applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0, '0);
      applyStimulus(1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'hDEADBEEF},
                    1'b0, '0, '0, '0);
      checkOutput("reset_rf_reg_write", 32'(rf_reg_write), 32'd0);
      checkOutput("reset_rf_rd", 32'(rf_rd), 32'd0);
      checkOutput("reset_rf_write_data", rf_write_data, 32'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

      $display("[TB] all requesters valid");
      for (int t = 0; t < 4; t++)
         applyStimulus(1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'hC, 32'hB, 32'hA},
                       1'b0, '0, '0, '0);
      drainReq();

      $display("[TB] RAW hazard on x10");
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd10, 5'd0, 5'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd0, 5'd10, 5'd0);
      applyStimulus(1'b0, 3'b010, {5'd0, 5'd10, 5'd0}, {32'h0, 32'h1234_5678, 32'h0},
                    1'b1, 5'd0, 5'd10, 5'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd0, 5'd10, 5'd0);

      $display("[TB] x0 handling");
      applyStimulus(1'b0, 3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'hFFFFFFFF},
                    1'b1, 5'd0, 5'd0, 5'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);

      $display("[TB] set wins over clear");
      applyStimulus(1'b0, 3'b100, {5'd7, 5'd0, 5'd0}, {32'h7777, 32'h0, 32'h0},
                    1'b1, 5'd7, 5'd0, 5'd0);
      applyStimulus(1'b0, '0, '0, '0, 1'b1, 5'd0, 5'd0, 5'd7);
      applyStimulus(1'b0, 3'b010, {5'd0, 5'd7, 5'd0}, {32'h0, 32'h7070, 32'h0},
                    1'b0, '0, '0, '0);

      $display("[TB] reset after a grant");
      applyStimulus(1'b0, 3'b100, {5'd4, 5'd0, 5'd0}, {32'h4444, 32'h0, 32'h0},
                    1'b0, '0, '0, '0);
      applyStimulus(1'b1, '0, '0, '0, 1'b0, '0, '0, '0);
      applyStimulus(1'b0, 3'b011, {5'd0, 5'd9, 5'd8}, {32'h0, 32'h9, 32'h8},
                    1'b0, '0, '0, '0);
      checkOutput("post_reset_grant", 32'(req_ready), 32'd1);
      drainReq();

      $display("[TB] randomized traffic");
      for (int t = 0; t < 1500; t++) randomStep();
      drainReq();
      for (int t = 0; t < 3; t++) applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
      checkOutput("pending_writes", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
